// File: rtl/popcount_accum_pkg.sv
// Shared widths and record layout for the popcount frame accumulator.
package popcount_accum_pkg;

   // Width of one bit-count result for a word of the given width.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

   // Width needed for the sum of a whole frame of counts.
   function automatic int tot_w(input int width, input int frame_len);
      return $clog2(width * frame_len + 1);
   endfunction

   // Width needed to hold a frame length of 1..frame_len.
   function automatic int len_w(input int frame_len);
      return $clog2(frame_len + 1);
   endfunction

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_FRAME_LEN = 4;
   localparam int DEF_CW        = $clog2(DEF_WIDTH + 1);
   localparam int DEF_TW        = $clog2(DEF_WIDTH * DEF_FRAME_LEN + 1);
   localparam int DEF_LW        = $clog2(DEF_FRAME_LEN + 1);

   // Frame record at the default parameterisation; the top builds the
   // same layout locally for whatever WIDTH/FRAME_LEN it is given.
   typedef struct packed {
      logic [DEF_TW-1:0] total;
      logic [DEF_CW-1:0] max;
      logic [DEF_LW-1:0] len;
   } frame_rec_t;

endpackage

// File: rtl/popcount_accum_rec_fifo.sv
// Two-entry synchronous FIFO holding closed frame records.
// Occupancy is registered so full/empty never depend on same-cycle push/pop.
module rec_fifo #(
   parameter int REC_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [REC_W-1:0] rec,
   output logic             full,
   output logic             empty,
   output logic [REC_W-1:0] head
);

   logic [REC_W-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage, pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= rec;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         if (do_push && !do_pop) begin
            count <= count + 2'd1;
         end else if (!do_push && do_pop) begin
            count <= count - 2'd1;
         end
      end
   end

endmodule

// File: rtl/popcount_accum.sv
// Frame accumulator for bit-count results: sums counts over a frame, tracks
// the largest count, and queues one {total, max, len} record per frame.
module popcount_accum
   import popcount_accum_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 4,
   localparam int CW       = cnt_w(WIDTH),
   localparam int TW       = tot_w(WIDTH, FRAME_LEN),
   localparam int LW       = len_w(FRAME_LEN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [CW-1:0] in_count,
   output logic          in_ready,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [TW-1:0] out_total,
   output logic [CW-1:0] out_max,
   output logic [LW-1:0] out_len
);

   typedef struct packed {
      logic [TW-1:0] total;
      logic [CW-1:0] max;
      logic [LW-1:0] len;
   } rec_t;

   localparam int REC_W = $bits(rec_t);

   logic [TW-1:0] acc_total;
   logic [CW-1:0] acc_max;
   logic [LW-1:0] acc_len;

   logic [TW-1:0] next_total;
   logic [CW-1:0] next_max;
   logic [LW-1:0] next_len;
   logic          accept;
   logic          close;
   rec_t          close_rec;
   rec_t          head_rec;

   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic [REC_W-1:0] fifo_head;

   assign in_ready  = !fifo_full;
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign accept    = in_valid && in_ready;

   // Post-accept view of the frame and the decision to close it this cycle.
   always_comb begin
      next_total = acc_total;
      next_max   = acc_max;
      next_len   = acc_len;
      if (accept) begin
         next_total = acc_total + TW'(in_count);
         next_max   = (in_count > acc_max) ? in_count : acc_max;
         next_len   = acc_len + LW'(1);
      end
      close = in_ready &&
              ((accept && (next_len == LW'(FRAME_LEN))) ||
               (flush && (next_len != '0)));
      close_rec.total = next_total;
      close_rec.max   = next_max;
      close_rec.len   = next_len;
   end

   // Running accumulators; a close hands the frame to the FIFO and starts afresh.
   always_ff @(posedge clk) begin
      if (rst || close) begin
         acc_total <= '0;
         acc_max   <= '0;
         acc_len   <= '0;
      end else if (accept) begin
         acc_total <= next_total;
         acc_max   <= next_max;
         acc_len   <= next_len;
      end
   end

   rec_fifo #(
      .REC_W (REC_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (close),
      .pop   (pop),
      .rec   (close_rec),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   assign head_rec  = rec_t'(fifo_head);
   assign out_total = head_rec.total;
   assign out_max   = head_rec.max;
   assign out_len   = head_rec.len;

endmodule

// File: tb/tb_popcount_accum.sv
// Directed self-checking bench for popcount_accum at WIDTH=8, FRAME_LEN=4.
module tb_popcount_accum;
   import popcount_accum_pkg::*;

   localparam int WIDTH     = 8;
   localparam int FRAME_LEN = 4;
   localparam int CW        = cnt_w(WIDTH);
   localparam int TW        = tot_w(WIDTH, FRAME_LEN);
   localparam int LW        = len_w(FRAME_LEN);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [CW-1:0] in_count;
   logic          in_ready;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [TW-1:0] out_total;
   logic [CW-1:0] out_max;
   logic [LW-1:0] out_len;

   int errors = 0;
   int checks = 0;

   popcount_accum #(
      .WIDTH     (WIDTH),
      .FRAME_LEN (FRAME_LEN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_count  (in_count),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_total (out_total),
      .out_max   (out_max),
      .out_len   (out_len)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Drive one cycle of inputs, then settle 1 unit past the rising edge.
   task automatic applyStimulus(input logic v, input int c, input logic f);
      in_valid = v;
      in_count = CW'(c);
      flush    = f;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkRecord(input string tag, input int total, input int max,
                              input int len);
      checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, ".total"}, 32'(out_total), 32'(total));
      checkOutput({tag, ".max"},   32'(out_max),   32'(max));
      checkOutput({tag, ".len"},   32'(out_len),   32'(len));
   endtask

   // Linear directed sequence covering reset, frames, flush, backpressure and mid-frame reset.
   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_count  = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      rst = 1'b0;
      checkOutput("reset.in_ready",  32'(in_ready),  32'd1);
      checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset.out_total", 32'(out_total), 32'd0);
      checkOutput("reset.out_max",   32'(out_max),   32'd0);
      checkOutput("reset.out_len",   32'(out_len),   32'd0);

      // Full frame 3, 8, 0, 5
      applyStimulus(1, 3, 0);
      checkOutput("full.c1.valid", 32'(out_valid), 32'd0);
      applyStimulus(1, 8, 0);
      checkOutput("full.c2.valid", 32'(out_valid), 32'd0);
      applyStimulus(1, 0, 0);
      checkOutput("full.c3.valid", 32'(out_valid), 32'd0);
      applyStimulus(1, 5, 0);
      checkRecord("full.rec", 16, 8, 4);
      applyStimulus(0, 0, 0);
      checkOutput("full.popped.valid", 32'(out_valid), 32'd0);

      // Flush a partial frame 2, 7, then 1 together with flush
      applyStimulus(1, 2, 0);
      applyStimulus(1, 7, 0);
      checkOutput("flush.pre.valid", 32'(out_valid), 32'd0);
      applyStimulus(1, 1, 1);
      checkRecord("flush.rec", 10, 7, 3);
      applyStimulus(0, 0, 1);
      checkOutput("flush.empty.valid", 32'(out_valid), 32'd0);
      applyStimulus(0, 0, 0);
      checkOutput("flush.empty.valid2", 32'(out_valid), 32'd0);

      // Backpressure: eight counts of 8 with out_ready low
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(1, 8, 0);
      checkRecord("bp.rec1", 32, 8, 4);
      checkOutput("bp.one.in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) applyStimulus(1, 8, 0);
      checkOutput("bp.full.in_ready", 32'(in_ready), 32'd0);
      applyStimulus(1, 8, 0);
      checkOutput("bp.stall.in_ready", 32'(in_ready), 32'd0);
      checkRecord("bp.hold", 32, 8, 4);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      applyStimulus(0, 0, 0);
      checkOutput("bp.pop1.in_ready", 32'(in_ready), 32'd1);
      checkRecord("bp.rec2", 32, 8, 4);
      applyStimulus(0, 0, 0);
      checkOutput("bp.drained.valid", 32'(out_valid), 32'd0);
      checkOutput("bp.drained.in_ready", 32'(in_ready), 32'd1);

      // Simultaneous push and pop at occupancy 1
      applyStimulus(1, 1, 1);
      checkRecord("pp.first", 1, 1, 1);
      applyStimulus(1, 6, 1);
      checkRecord("pp.second", 6, 6, 1);
      checkOutput("pp.in_ready", 32'(in_ready), 32'd1);
      applyStimulus(0, 0, 0);
      checkOutput("pp.drained.valid", 32'(out_valid), 32'd0);

      // Reset mid-frame discards 4, 4
      applyStimulus(1, 4, 0);
      applyStimulus(1, 4, 0);
      rst = 1'b1;
      applyStimulus(0, 0, 0);
      rst = 1'b0;
      checkOutput("mid.reset.valid", 32'(out_valid), 32'd0);
      checkOutput("mid.reset.total", 32'(out_total), 32'd0);
      applyStimulus(1, 1, 0);
      applyStimulus(1, 1, 0);
      applyStimulus(1, 1, 0);
      checkOutput("mid.c3.valid", 32'(out_valid), 32'd0);
      applyStimulus(1, 1, 0);
      checkRecord("mid.rec", 4, 1, 4);
      applyStimulus(0, 0, 0);
      checkOutput("mid.drained.valid", 32'(out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
